// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared encodings for the execute stage (ALU ops, M-op/branch funct3, forward selects, MD FSM states)
package rv_core_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
  localparam logic [2:0] F3_MUL = 3'd0, F3_MULH = 3'd1, F3_MULHSU = 3'd2, F3_MULHU = 3'd3;
  localparam logic [2:0] F3_DIV = 3'd4, F3_DIVU = 3'd5, F3_REM = 3'd6, F3_REMU = 3'd7;
  localparam logic [2:0] BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd4, BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7;
  localparam logic [1:0] FWD_REG = 2'd0, FWD_W = 2'd1, FWD_M = 2'd2, FWD_ZERO = 2'd3;
endpackage

// File: rtl/md_unit.sv
// md_unit: iterative RV M-extension unit, one bit per cycle on operand magnitudes with sign fix-up at the end
module md_unit
  import rv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            flush,
  input  logic            stall,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  md_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] hi, lo, opd, am, bm;
  logic [2:0] op_q;
  logic an, bn, an_q, bn_q, start;
  logic [XLEN:0] sum, r_sh;
  logic [2*XLEN-1:0] prod;
  always_ff @(posedge clk)
    if (rst) state <= MD_IDLE;
    else state <= state_n;
  always_comb
    state_n = flush ? MD_IDLE :
              state == MD_IDLE ? (valid ? MD_BUSY : MD_IDLE) :
              state == MD_BUSY ? (cnt == CW'(1) ? MD_DONE : MD_BUSY) :
              stall ? MD_DONE : MD_IDLE;
  always_comb begin
    start = state == MD_IDLE && valid && !flush;
    busy  = start || state == MD_BUSY;
    done  = state == MD_DONE;
  end
  assign an = op inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM} && a[XLEN-1];
  assign bn = op inside {F3_MULH, F3_DIV, F3_REM} && b[XLEN-1];
  assign am = an ? -a : a;
  assign bm = bn ? -b : b;
  // multiply: {hi,lo} holds partial product over the shifting multiplier; divide: hi = remainder, lo = dividend -> quotient
  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
  assign r_sh = {hi, lo[XLEN-1]};
  always_ff @(posedge clk)
    if (rst) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      opd  <= '0;
      op_q <= '0;
      an_q <= 1'b0;
      bn_q <= 1'b0;
    end else if (start) begin
      cnt  <= CW'(XLEN);
      hi   <= '0;
      lo   <= op[2] ? am : bm;
      opd  <= op[2] ? bm : am;
      op_q <= op;
      an_q <= an;
      bn_q <= bn;
    end else if (state == MD_BUSY && !flush) begin
      cnt <= cnt - CW'(1);
      if (op_q[2]) begin
        hi <= r_sh >= {1'b0, opd} ? XLEN'(r_sh - {1'b0, opd}) : r_sh[XLEN-1:0];
        lo <= {lo[XLEN-2:0], r_sh >= {1'b0, opd}};
      end else
        {hi, lo} <= {sum, lo[XLEN-1:1]};
    end
  assign prod = (an_q ^ bn_q) ? -{hi, lo} : {hi, lo};
  // a zero divisor forces an all-ones quotient regardless of the dividend's sign
  assign result = !op_q[2] ? (op_q == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                  !op_q[1] ? (opd == '0 ? '1 : (an_q ^ bn_q) ? -lo : lo) :
                  an_q ? -hi : hi;
endmodule

// File: rtl/execute_stage_md.sv
// execute_stage_md: EX stage with forwarding, ALU, branch resolution, iterative M unit and EX/MEM register
module execute_stage_md
  import rv_core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] result_w,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [RD_W-1:0] rd_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic            alu_src_e,
  input  logic            md_valid_e,
  input  logic [1:0]      result_src_e,
  input  logic [2:0]      funct3_e,
  input  logic [3:0]      alu_control_e,
  input  logic            stall_m,
  input  logic            flush_e,
  output logic            ex_busy,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [2:0]      funct3_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [RD_W-1:0] rd_m
);
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] src_a, src_b_fwd, src_b, alu_result, md_result;
  logic cond, md_done, bubble;
  assign src_a = forward_a_e == FWD_REG ? rd1_e : forward_a_e == FWD_W ? result_w :
                 forward_a_e == FWD_M ? alu_result_m : '0;
  assign src_b_fwd = forward_b_e == FWD_REG ? rd2_e : forward_b_e == FWD_W ? result_w :
                     forward_b_e == FWD_M ? alu_result_m : '0;
  assign src_b = alu_src_e ? imm_e : src_b_fwd;
  always_comb
    case (alu_control_e)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLTU: alu_result = XLEN'(src_a < src_b);
      ALU_SLL:  alu_result = src_a << src_b[SW-1:0];
      ALU_SRL:  alu_result = src_a >> src_b[SW-1:0];
      ALU_SRA:  alu_result = $signed(src_a) >>> src_b[SW-1:0];
      default:  alu_result = '0;
    endcase
  assign cond = funct3_e == BR_EQ  ? src_a == src_b_fwd :
                funct3_e == BR_NE  ? src_a != src_b_fwd :
                funct3_e == BR_LT  ? $signed(src_a) < $signed(src_b_fwd) :
                funct3_e == BR_GE  ? $signed(src_a) >= $signed(src_b_fwd) :
                funct3_e == BR_LTU ? src_a < src_b_fwd :
                funct3_e == BR_GEU ? src_a >= src_b_fwd : 1'b0;
  assign pc_target_e = jalr_e ? (src_a + imm_e) & ~XLEN'(1) : pc_e + imm_e;
  assign pc_src_e = !flush_e && (jump_e || (branch_e && cond));
  md_unit #(.XLEN(XLEN)) u_md (
    .clk(clk), .rst(rst), .valid(md_valid_e), .flush(flush_e), .stall(stall_m),
    .op(funct3_e), .a(src_a), .b(src_b_fwd),
    .busy(ex_busy), .done(md_done), .result(md_result)
  );
  assign bubble = flush_e || ex_busy;
  always_ff @(posedge clk)
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      funct3_m     <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
    end else if (!stall_m) begin
      reg_write_m  <= !bubble && reg_write_e;
      mem_write_m  <= !bubble && mem_write_e;
      result_src_m <= bubble ? '0 : result_src_e;
      funct3_m     <= bubble ? '0 : funct3_e;
      alu_result_m <= bubble ? '0 : (md_valid_e && md_done) ? md_result : alu_result;
      write_data_m <= bubble ? '0 : src_b_fwd;
      pc_plus4_m   <= bubble ? '0 : pc_plus4_e;
      rd_m         <= bubble ? '0 : rd_e;
    end
endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: randomized + directed checks of execute_stage_md against a plain-arithmetic model
module tb_execute_stage_md;
  import rv_core_pkg::*;
  localparam int XLEN = 32, RD_W = 5;
  logic clk = 1'b0, rst;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, result_w;
  logic [1:0] forward_a_e, forward_b_e, result_src_e;
  logic [4:0] rd_e;
  logic reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e, md_valid_e;
  logic [2:0] funct3_e;
  logic [3:0] alu_control_e;
  logic stall_m, flush_e;
  logic ex_busy, pc_src_e, reg_write_m, mem_write_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [1:0] result_src_m;
  logic [2:0] funct3_m;
  logic [4:0] rd_m;
  logic [31:0] m_alu = 0, m_wd = 0, m_pc4 = 0;
  logic [4:0] m_rd = 0;
  logic m_rw = 0, m_mw = 0;
  int tests = 0, fails = 0;

  execute_stage_md #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .result_w(result_w), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .alu_src_e(alu_src_e), .md_valid_e(md_valid_e),
    .result_src_e(result_src_e), .funct3_e(funct3_e), .alu_control_e(alu_control_e),
    .stall_m(stall_m), .flush_e(flush_e), .ex_busy(ex_busy), .pc_src_e(pc_src_e),
    .pc_target_e(pc_target_e), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .result_src_m(result_src_m), .funct3_m(funct3_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r);
    return s == 2'd0 ? r : s == 2'd1 ? result_w : s == 2'd2 ? m_alu : 32'd0;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return $signed(a) < $signed(b) ? 32'd1 : 32'd0;
      4'd6: return a < b ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a)), sb = longint'($signed(b)), ub = longint'({32'd0, b});
    logic [63:0] p;
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic quiet();
    {rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, result_w} = '0;
    {forward_a_e, forward_b_e, result_src_e, rd_e, funct3_e, alu_control_e} = '0;
    {reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e, md_valid_e, stall_m, flush_e} = '0;
  endtask

  task automatic ex_step();
    logic [31:0] a, bf, b, tgt;
    logic take;
    a = fwd(forward_a_e, rd1_e);
    bf = fwd(forward_b_e, rd2_e);
    b = alu_src_e ? imm_e : bf;
    take = !flush_e && (jump_e || (branch_e && br_ref(funct3_e, a, bf)));
    tgt = jalr_e ? ((a + imm_e) & ~32'd1) : pc_e + imm_e;
    #1;
    chk("pc_src", 32'(pc_src_e), 32'(take));
    chk("pc_target", pc_target_e, tgt);
    if (!stall_m) begin
      m_alu = flush_e ? 32'd0 : alu_ref(alu_control_e, a, b);
      m_wd = flush_e ? 32'd0 : bf;
      m_pc4 = flush_e ? 32'd0 : pc_plus4_e;
      m_rd = flush_e ? 5'd0 : rd_e;
      m_rw = !flush_e && reg_write_e;
      m_mw = !flush_e && mem_write_e;
    end
    @(negedge clk);
    chk("alu_result_m", alu_result_m, m_alu);
    chk("write_data_m", write_data_m, m_wd);
    chk("pc_plus4_m", pc_plus4_m, m_pc4);
    chk("rd_m", 32'(rd_m), 32'(m_rd));
    chk("reg_write_m", 32'(reg_write_m), 32'(m_rw));
    chk("mem_write_m", 32'(mem_write_m), 32'(m_mw));
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int stall_n);
    int n = 0;
    quiet();
    md_valid_e = 1'b1;
    funct3_e = op;
    rd1_e = a;
    rd2_e = b;
    reg_write_e = 1'b1;
    rd_e = 5'($urandom);
    #1;
    chk("busy_accept", 32'(ex_busy), 32'd1);
    while (ex_busy && n < 80) begin
      n++;
      @(negedge clk);
      rd1_e = $urandom;
      rd2_e = $urandom;
    end
    chk("busy_len", n, 33);
    rd1_e = a;
    rd2_e = b;
    {m_alu, m_wd, m_pc4, m_rd, m_rw, m_mw} = '0;
    if (stall_n > 0) begin
      stall_m = 1'b1;
      for (int k = 0; k < stall_n; k++) begin
        @(negedge clk);
        chk("stall_busy", 32'(ex_busy), 32'd0);
        chk("stall_hold", alu_result_m, 32'd0);
      end
      stall_m = 1'b0;
    end
    m_alu = exp;
    m_wd = b;
    m_rd = rd_e;
    m_rw = 1'b1;
    @(negedge clk);
    chk("md_result", alu_result_m, exp);
    chk("md_wdata", write_data_m, m_wd);
    chk("md_rd", 32'(rd_m), 32'(m_rd));
    md_valid_e = 1'b0;
    reg_write_e = 1'b0;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_alu", alu_result_m, 0);
    chk("rst_wd", write_data_m, 0);
    chk("rst_rw", 32'(reg_write_m), 0);
    chk("rst_busy", 32'(ex_busy), 0);
    // forwarding
    quiet(); rd1_e = 9; alu_src_e = 1; reg_write_e = 1; ex_step();
    quiet(); rd1_e = 5; forward_a_e = 2'b10; alu_src_e = 1; imm_e = 1; ex_step();
    chk("fwd_m_add", alu_result_m, 32'd10);
    quiet(); forward_b_e = 2'b01; result_w = 32'hAB; mem_write_e = 1; alu_src_e = 1; ex_step();
    chk("fwd_w_store", write_data_m, 32'hAB);
    // branches and jalr
    quiet(); rd1_e = 32'hFFFF_FFFF; rd2_e = 1; branch_e = 1; funct3_e = BR_LT;
    #1 chk("blt_taken", 32'(pc_src_e), 1); ex_step();
    quiet(); rd1_e = 32'hFFFF_FFFF; rd2_e = 1; branch_e = 1; funct3_e = BR_LTU;
    #1 chk("bltu_not", 32'(pc_src_e), 0); ex_step();
    quiet(); rd1_e = 32'h101; imm_e = 2; jalr_e = 1; jump_e = 1;
    #1 chk("jalr_tgt", pc_target_e, 32'h102); chk("jalr_src", 32'(pc_src_e), 1); ex_step();
    // random ALU/branch traffic
    for (int i = 0; i < 60; i++) begin
      rd1_e = $urandom; rd2_e = $urandom; imm_e = $urandom; pc_e = $urandom;
      pc_plus4_e = pc_e + 4; result_w = $urandom;
      if ($urandom_range(0, 3) == 0) rd2_e = rd1_e;
      forward_a_e = 2'($urandom); forward_b_e = 2'($urandom); alu_src_e = 1'($urandom);
      alu_control_e = 4'($urandom); funct3_e = 3'($urandom); branch_e = 1'($urandom);
      jump_e = $urandom_range(0, 3) == 0; jalr_e = 1'($urandom); rd_e = 5'($urandom);
      reg_write_e = 1'($urandom); mem_write_e = 1'($urandom); result_src_e = 2'($urandom);
      md_valid_e = 0; flush_e = $urandom_range(0, 7) == 0; stall_m = $urandom_range(0, 7) == 0;
      ex_step();
    end
    quiet();
    // M-op corners
    run_md(F3_MUL,   32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 0);
    run_md(F3_MULH,  32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 0);
    run_md(F3_MULHU, 32'hFFFF_FFFF, 2, 32'h0000_0001, 0);
    run_md(F3_DIV,   7, 0, 32'hFFFF_FFFF, 0);
    run_md(F3_REM,   7, 0, 7, 0);
    run_md(F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_md(F3_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_md(F3_DIV,   32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 3);
    run_md(F3_REM,   32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 14; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom); a = $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      run_md(op, a, b, md_ref(op, a, b), $urandom_range(0, 1) * 2);
    end
    // flush in the middle of a divide
    quiet(); md_valid_e = 1; funct3_e = F3_DIV; rd1_e = 1000; rd2_e = 7; reg_write_e = 1;
    repeat (10) @(negedge clk);
    flush_e = 1;
    @(negedge clk);
    flush_e = 0; md_valid_e = 0;
    #1;
    chk("flush_busy", 32'(ex_busy), 0);
    chk("flush_bubble", 32'(reg_write_m), 0);
    {m_alu, m_wd, m_pc4, m_rd, m_rw, m_mw} = '0;
    @(negedge clk);
    run_md(F3_DIVU, 1000, 7, 32'd142, 0);
    // reset in the middle of a multiply while M is held
    quiet(); rd1_e = 32'h1234; alu_src_e = 1; reg_write_e = 1; rd_e = 3; ex_step();
    quiet(); md_valid_e = 1; funct3_e = F3_MUL; rd1_e = 3; rd2_e = 5; stall_m = 1;
    repeat (5) @(negedge clk);
    chk("stall_during_busy", alu_result_m, 32'h1234);
    rst = 1;
    @(negedge clk);
    rst = 0; md_valid_e = 0; stall_m = 0;
    #1;
    chk("rst_mid_busy", 32'(ex_busy), 0);
    chk("rst_mid_alu", alu_result_m, 0);
    chk("rst_mid_rw", 32'(reg_write_m), 0);
    chk("rst_mid_rd", 32'(rd_m), 0);
    {m_alu, m_wd, m_pc4, m_rd, m_rw, m_mw} = '0;
    @(negedge clk);
    run_md(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
